// File: rtl/crypto_seq_pkg.sv
// crypto_seq_pkg: shared state encoding, counter width and default widths for the crypto sequencer
package crypto_seq_pkg;
  localparam int CNT_W = 16;
  localparam int TEXT_W = 128;
  localparam int KEY_W = 128;
  localparam int TIMEOUT_DEF = 1024;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, RUN} state_e;
endpackage

// File: rtl/crypto_seq_counter.sv
// crypto_seq_counter: 16-bit clear/enable/saturating counter with terminal-count compare
module crypto_seq_counter
  import crypto_seq_pkg::*;
#(
  parameter int unsigned LIMIT = 2**CNT_W - 1
) (
  input  logic             crypt_clk,
  input  logic             crypt_rstn,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // clear wins over count; hold at all-ones instead of wrapping
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  // count register
  always_ff @(posedge crypt_clk or negedge crypt_rstn)
    if (!crypt_rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign tc_o = cnt_q == CNT_W'(LIMIT);
endmodule

// File: rtl/crypto_sequencer.sv
// crypto_sequencer: start/load/busy/done handshake to an iterative cipher core; define CRYPTO_SEQ_CYCLE_COUNT_EN to report latency on cycles_o
module crypto_sequencer
  import crypto_seq_pkg::*;
#(
  parameter int TEXT_WIDTH = TEXT_W,
  parameter int KEY_WIDTH = KEY_W,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                  crypt_clk,
  input  logic                  crypt_rstn,
  input  logic                  start_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  input  logic [TEXT_WIDTH-1:0] text_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [TEXT_WIDTH-1:0] cipher_o,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      cycles_o,
  output logic                  core_load_o,
  output logic [KEY_WIDTH-1:0]  core_key_o,
  output logic [TEXT_WIDTH-1:0] core_text_o,
  input  logic                  core_busy_i,
  input  logic [TEXT_WIDTH-1:0] core_data_i,
  output logic                  trigger_o
);
  state_e state_q, state_d;
  logic start_q, start_d, ready_q, ready_d, done_q, done_d, timeout_q, timeout_d;
  logic load_q, load_d, trig_q, trig_d;
  logic [TEXT_WIDTH-1:0] cipher_q, cipher_d, text_q, text_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic accept, active, finish, expire, to_tc;
  logic [CNT_W-1:0] to_cnt_unused;

  assign accept = state_q == IDLE && start_i && !start_q;
  assign active = state_q == WAIT_BUSY || state_q == RUN;
  assign finish = state_q == RUN && !core_busy_i;
  assign expire = active && !finish && to_tc;

  crypto_seq_counter #(.LIMIT(TIMEOUT_CYCLES - 1)) u_timeout (
    .crypt_clk (crypt_clk),
    .crypt_rstn(crypt_rstn),
    .clr_i     (accept),
    .en_i      (active),
    .cnt_o     (to_cnt_unused),
    .tc_o      (to_tc)
  );

  // next state and handshake outputs; completion takes priority over timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = accept ? LOAD : IDLE;
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = expire ? IDLE : core_busy_i ? RUN : WAIT_BUSY;
      RUN:       state_d = (finish || expire) ? IDLE : RUN;
      default:   state_d = IDLE;
    endcase
    start_d = start_i;
    load_d = accept;
    trig_d = accept ? 1'b1 : (finish || expire) ? 1'b0 : trig_q;
    ready_d = accept ? 1'b0 : (finish || expire) ? 1'b1 : ready_q;
    done_d = accept ? 1'b0 : finish ? 1'b1 : done_q;
    timeout_d = accept ? 1'b0 : expire ? 1'b1 : timeout_q;
    cipher_d = finish ? core_data_i : cipher_q;
    key_d = accept ? key_i : key_q;
    text_d = accept ? text_i : text_q;
  end

  // state and output registers; start_q resets high so a held start is not a request
  always_ff @(posedge crypt_clk or negedge crypt_rstn)
    if (!crypt_rstn) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      ready_q <= 1'b1;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
      load_q <= 1'b0;
      trig_q <= 1'b0;
      cipher_q <= '0;
      key_q <= '0;
      text_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      ready_q <= ready_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
      load_q <= load_d;
      trig_q <= trig_d;
      cipher_q <= cipher_d;
      key_q <= key_d;
      text_q <= text_d;
    end

`ifdef CRYPTO_SEQ_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cyc_cnt, cycles_q, cycles_d;
  logic cyc_sat;

  crypto_seq_counter #(.LIMIT(2**CNT_W - 1)) u_cycles (
    .crypt_clk (crypt_clk),
    .crypt_rstn(crypt_rstn),
    .clr_i     (accept),
    .en_i      (state_q != IDLE),
    .cnt_o     (cyc_cnt),
    .tc_o      (cyc_sat)
  );

  // latch accept-to-completion edge count, including the completion edge itself
  always_comb cycles_d = finish ? cyc_cnt + CNT_W'(!cyc_sat) : cycles_q;
  // latency register, untouched on timeout
  always_ff @(posedge crypt_clk or negedge crypt_rstn)
    if (!crypt_rstn) cycles_q <= '0;
    else cycles_q <= cycles_d;
  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

  assign ready_o = ready_q;
  assign done_o = done_q;
  assign cipher_o = cipher_q;
  assign timeout_o = timeout_q;
  assign core_load_o = load_q;
  assign core_key_o = key_q;
  assign core_text_o = text_q;
  assign trigger_o = trig_q;
endmodule

// File: tb/tb_crypto_sequencer.sv
// tb_crypto_sequencer: randomized and directed checks of crypto_sequencer against a transaction-level model
module tb_crypto_sequencer;
  localparam int T = 64;
`ifdef CRYPTO_SEQ_CYCLE_COUNT_EN
  localparam bit CYC = 1'b1;
`else
  localparam bit CYC = 1'b0;
`endif
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic crypt_clk = 1'b0, crypt_rstn = 1'b0, start_i = 1'b1, core_busy_i = 1'b0;
  logic [127:0] key_i = '0, text_i = '0, core_data_i = '0;
  logic ready_o, done_o, timeout_o, core_load_o, trigger_o;
  logic [127:0] cipher_o, core_key_o, core_text_o;
  logic [15:0] cycles_o;

  crypto_sequencer #(.TEXT_WIDTH(128), .KEY_WIDTH(128), .TIMEOUT_CYCLES(T)) dut (
    .crypt_clk(crypt_clk), .crypt_rstn(crypt_rstn), .start_i(start_i), .key_i(key_i), .text_i(text_i),
    .ready_o(ready_o), .done_o(done_o), .cipher_o(cipher_o), .timeout_o(timeout_o), .cycles_o(cycles_o),
    .core_load_o(core_load_o), .core_key_o(core_key_o), .core_text_o(core_text_o),
    .core_busy_i(core_busy_i), .core_data_i(core_data_i), .trigger_o(trigger_o)
  );

  always #5 crypt_clk = ~crypt_clk;

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge crypt_clk);
  endtask

  // transaction-level model: an in-flight request with its age in edges since acceptance
  bit m_prev, m_active, m_seen;
  int m_age;
  logic [127:0] e_key, e_text, e_cipher;
  logic e_load, e_trig, e_ready, e_done, e_to;
  logic [15:0] e_cyc;

  task model_reset();
    m_prev = 1'b1; m_active = 1'b0; m_seen = 1'b0; m_age = 0;
    e_key = '0; e_text = '0; e_cipher = '0; e_cyc = '0;
    e_load = 1'b0; e_trig = 1'b0; e_ready = 1'b1; e_done = 1'b0; e_to = 1'b0;
  endtask

  task model_step();
    bit rise;
    rise = start_i && !m_prev;
    m_prev = start_i;
    e_load = 1'b0;
    if (!m_active) begin
      if (rise) begin
        m_active = 1'b1; m_age = 0; m_seen = 1'b0;
        e_key = key_i; e_text = text_i;
        e_load = 1'b1; e_trig = 1'b1; e_ready = 1'b0; e_done = 1'b0; e_to = 1'b0;
      end
    end else begin
      if (m_age >= 1) begin
        if (m_seen && !core_busy_i) begin
          e_cipher = core_data_i; e_done = 1'b1; e_ready = 1'b1; e_trig = 1'b0; m_active = 1'b0;
          e_cyc = (m_age + 1 > 65535) ? 16'hffff : 16'(m_age + 1);
        end else if (m_age == T) begin
          e_to = 1'b1; e_ready = 1'b1; e_trig = 1'b0; m_active = 1'b0;
        end else if (core_busy_i) m_seen = 1'b1;
      end
      m_age++;
    end
  endtask

  initial model_reset();

  always @(posedge crypt_clk) begin
    if (!crypt_rstn) model_reset();
    else model_step();
    #1;
    chk("ready", ready_o, e_ready);
    chk("done", done_o, e_done);
    chk("cipher", cipher_o, e_cipher);
    chk("timeout", timeout_o, e_to);
    chk("cycles", cycles_o, CYC ? e_cyc : 16'd0);
    chk("load", core_load_o, e_load);
    chk("key", core_key_o, e_key);
    chk("text", core_text_o, e_text);
    chk("trigger", trigger_o, e_trig);
  end

  // core model: busy rises c_dly cycles after it sees load and stays up c_len cycles (0 = never)
  int c_dly = 1, c_len = 11, c_wait = 0, c_run = 0;
  logic [127:0] c_data = CT;
  bit rand_core = 1'b0;

  always @(negedge crypt_clk) begin
    if (!crypt_rstn) begin
      core_busy_i = 1'b0; c_wait = 0;
    end else if (core_load_o) begin
      if (rand_core) begin
        c_dly = ($urandom % 8 == 0) ? T + 8 : 1 + int'($urandom % 4);
        c_len = ($urandom % 8 == 0) ? 0 : ($urandom % 8 == 0) ? T + 8 : 1 + int'($urandom % 15);
        c_data = {$urandom, $urandom, $urandom, $urandom};
      end
      c_wait = c_dly; c_run = c_len; core_busy_i = 1'b0;
    end else if (c_wait > 0) begin
      c_wait--;
      if (c_wait == 0 && c_run > 0) core_busy_i = 1'b1;
    end else if (core_busy_i) begin
      core_data_i = {$urandom, $urandom, $urandom, $urandom};
      c_run--;
      if (c_run == 0) begin
        core_busy_i = 1'b0; core_data_i = c_data;
      end
    end
  end

  task automatic wait_ready(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 4 * T && !ok; i++) begin
      @(negedge crypt_clk);
      ok = ready_o;
    end
    chk(name, ok, 1'b1);
  endtask

  initial begin
    int nl, nt, n, nd;
    bit got, pd;
    logic [127:0] k2, ct2;
    tick(3);
    crypt_rstn = 1'b1;
    tick(4);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_load", core_load_o, 1'b0);
    chk("rst_trig", trigger_o, 1'b0);
    chk("rst_cipher", cipher_o, '0);
    start_i = 1'b0;
    tick(2);
    key_i = KEY; text_i = PT; c_dly = 1; c_len = 11; c_data = CT; start_i = 1'b1;
    nl = 0; nt = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge crypt_clk);
      nl += int'(core_load_o); nt += int'(trigger_o); got = done_o;
    end
    chk("dir_done", got, 1'b1);
    chk("dir_load_len", nl, 1);
    chk("dir_trig_len", nt, 13);
    chk("dir_cipher", cipher_o, CT);
    chk("dir_cycles", cycles_o, CYC ? 16'd13 : 16'd0);
    chk("dir_key", core_key_o, KEY);
    start_i = 1'b0; c_len = 0;
    tick(2);
    start_i = 1'b1;
    n = 0;
    while (n < T + 20 && !timeout_o) begin
      @(negedge crypt_clk);
      n++;
    end
    chk("to_latency", n, T + 2);
    chk("to_ready", ready_o, 1'b1);
    chk("to_done", done_o, 1'b0);
    chk("to_cipher", cipher_o, CT);
    chk("to_cycles", cycles_o, CYC ? 16'd13 : 16'd0);
    ct2 = 128'h0123456789abcdef0011223344556677;
    start_i = 1'b0; c_len = 5; c_data = ct2;
    tick(2);
    start_i = 1'b1;
    tick(1);
    chk("to_clear", timeout_o, 1'b0);
    wait_ready("to_good_done");
    chk("to_good_cipher", cipher_o, ct2);
    k2 = 128'hfeedfacecafebeef0badf00ddeadc0de;
    start_i = 1'b0; c_len = 10; key_i = k2;
    tick(2);
    start_i = 1'b1;
    tick(1);
    key_i = ~k2; start_i = 1'b0;
    tick(3);
    start_i = 1'b1; text_i = ~text_i;
    tick(2);
    start_i = 1'b0;
    tick(1);
    start_i = 1'b1;
    nd = 0; nl = 0; pd = done_o;
    for (int i = 0; i < 40; i++) begin
      @(negedge crypt_clk);
      if (done_o && !pd) nd++;
      pd = done_o; nl += int'(core_load_o);
    end
    chk("mid_dones", nd, 1);
    chk("mid_loads", nl, 0);
    chk("mid_key", core_key_o, k2);
    start_i = 1'b0; c_len = 30;
    tick(1);
    start_i = 1'b1;
    tick(6);
    @(posedge crypt_clk);
    #2 crypt_rstn = 1'b0;
    #1;
    chk("rst_run_trig", trigger_o, 1'b0);
    chk("rst_run_load", core_load_o, 1'b0);
    chk("rst_run_ready", ready_o, 1'b1);
    tick(2);
    start_i = 1'b0; crypt_rstn = 1'b1;
    tick(2);
    chk("rst_rel_ready", ready_o, 1'b1);
    c_len = 4; c_data = ~CT; start_i = 1'b1;
    tick(1);
    wait_ready("rst_after_done");
    chk("rst_after_cipher", cipher_o, ~CT);
    chk("rst_after_donef", done_o, 1'b1);
    start_i = 1'b0; c_dly = 1; c_len = 3; c_data = CT;
    tick(2);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    tick(4);
    start_i = 1'b1;
    tick(1);
    chk("b2b_ready", ready_o, 1'b1);
    chk("b2b_done", done_o, 1'b1);
    tick(2);
    chk("b2b_no_load", core_load_o, 1'b0);
    start_i = 1'b0;
    tick(1);
    start_i = 1'b1;
    tick(1);
    chk("b2b_accept", core_load_o, 1'b1);
    wait_ready("b2b_done2");
    rand_core = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge crypt_clk);
      if ($urandom % 5 == 0) start_i = ~start_i;
      if ($urandom % 3 == 0) key_i = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom % 3 == 0) text_i = {$urandom, $urandom, $urandom, $urandom};
    end
    start_i = 1'b0;
    tick(3 * T);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
